// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan capture block: glyph codes and
// active-high segment patterns ({g,f,e,d,c,b,a}) matching the display encoder.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] GLYPH_N     = 4'hA;
  localparam logic [3:0] GLYPH_O     = 4'hB;
  localparam logic [3:0] GLYPH_BLANK = 4'hC;
  localparam logic [3:0] GLYPH_D     = 4'hD;
  localparam logic [3:0] GLYPH_E     = 4'hE;
  localparam logic [3:0] GLYPH_BAD   = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_N     = 7'b1010100;
  localparam logic [6:0] SEG_O     = 7'b1011100;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the segment encoder: active-low segment bus in, glyph code out.
// Patterns the encoder never produces map to GLYPH_BAD with invalid raised.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  logic [6:0] pattern;

  assign pattern = ~seg;

  always_comb begin
    code    = GLYPH_BAD;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_N:     code = GLYPH_N;
      SEG_O:     code = GLYPH_O;
      SEG_BLANK: code = GLYPH_BLANK;
      SEG_D:     code = GLYPH_D;
      SEG_E:     code = GLYPH_E;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Watches a multiplexed anode/segment bus, samples each digit once it has been
// stable long enough, and publishes a complete 8-digit frame atomically.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  output logic [31:0] digits,
  output logic [7:0]  invalid_mask,
  output logic        frame_valid,
  output logic        an_err
);

  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [31:0] ALL_BLANK  = {NUM_DIGITS{GLYPH_BLANK}};

  logic [7:0]  an_sync  [SYNC_STAGES];
  logic [6:0]  seg_sync [SYNC_STAGES];
  logic [7:0]  an_s, prev_an, an_low, sel_mask;
  logic [6:0]  seg_s, prev_seg;
  logic [7:0]  settle_cnt, cnt_next;
  logic        captured, changed, settled;
  logic        one_hot, multi_low, capture, complete;
  logic [2:0]  sel_idx;
  logic [3:0]  code;
  logic        code_bad;
  logic [31:0] shadow;
  logic [7:0]  seen, seen_next, bad_rec;

  // Idle bus is all-ones, so the synchronizer resets to that rather than zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        an_sync[i]  <= '1;
        seg_sync[i] <= '1;
      end
    end else begin
      an_sync[0]  <= an;
      seg_sync[0] <= seg;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        an_sync[i]  <= an_sync[i-1];
        seg_sync[i] <= seg_sync[i-1];
      end
    end
  end

  assign an_s  = an_sync[SYNC_STAGES-1];
  assign seg_s = seg_sync[SYNC_STAGES-1];

  // cnt_next is the dwell age this cycle; a change restarts it at zero, which
  // lets SETTLE_CYCLES=1 fire on the very first cycle of a new value.
  always_comb begin
    changed = (an_s != prev_an) || (seg_s != prev_seg);
    if (changed)
      cnt_next = 8'd0;
    else if (settle_cnt == SETTLE_MAX)
      cnt_next = settle_cnt;
    else
      cnt_next = settle_cnt + 8'd1;
    settled = (cnt_next == SETTLE_MAX - 8'd1) && (changed || !captured);
  end

  assign an_low    = ~an_s;
  assign one_hot   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
  assign multi_low = (an_low != 8'h00) && !one_hot;

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_low[i]) sel_idx = 3'(i);
  end

  assign capture   = settled && one_hot;
  assign sel_mask  = 8'h01 << sel_idx;
  assign seen_next = (complete ? 8'h00 : seen) | (capture ? sel_mask : 8'h00);

  seg7_decode u_decode (
    .seg     (seg_s),
    .code    (code),
    .invalid (code_bad)
  );

  // Publishing reads shadow before any same-cycle capture lands, so a digit
  // captured while a frame is being published belongs to the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_an      <= '1;
      prev_seg     <= '1;
      settle_cnt   <= 8'd0;
      captured     <= 1'b0;
      shadow       <= ALL_BLANK;
      bad_rec      <= 8'h00;
      seen         <= 8'h00;
      complete     <= 1'b0;
      digits       <= ALL_BLANK;
      invalid_mask <= 8'h00;
      frame_valid  <= 1'b0;
      an_err       <= 1'b0;
    end else begin
      prev_an     <= an_s;
      prev_seg    <= seg_s;
      settle_cnt  <= cnt_next;
      if (settled)
        captured <= 1'b1;
      else if (changed)
        captured <= 1'b0;
      frame_valid <= complete;
      an_err      <= settled && multi_low;
      if (complete) begin
        digits       <= shadow;
        invalid_mask <= bad_rec;
      end
      if (capture) begin
        shadow[{sel_idx, 2'b00} +: 4] <= code;
        bad_rec[sel_idx]              <= code_bad;
      end
      seen     <= seen_next;
      complete <= capture && (seen_next == 8'hFF);
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scans plus randomized
// frames checked against a table-driven model of the scanned display.
module tb_seg_scan_capture;

  localparam int SETTLE = 4;
  localparam int SYNC   = 2;
  localparam int WAIT_N = SYNC + SETTLE + 4;

  localparam logic [6:0] PAT_TAB [15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
    7'b1010100, 7'b1011100, 7'b0000000, 7'b1011110, 7'b1111001
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] digits;
  logic [7:0]  invalid_mask;
  logic        frame_valid;
  logic        an_err;

  int vectors = 0;
  int miscompares = 0;
  int fv_count = 0;
  int err_count = 0;

  logic [3:0]  m_code [8];
  logic        m_bad  [8];
  bit          m_seen [8];
  int          exp_frames = 0;
  int          exp_errs = 0;
  logic [31:0] exp_digits = 32'hCCCC_CCCC;
  logic [7:0]  exp_mask = 8'h00;

  seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .seg          (seg),
    .digits       (digits),
    .invalid_mask (invalid_mask),
    .frame_valid  (frame_valid),
    .an_err       (an_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_count++;
    if (an_err === 1'b1) err_count++;
  end

  // Glyph code is simply the position of the pattern in PAT_TAB.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 15; k++)
      if (PAT_TAB[k] == p) return {1'b0, 4'(k)};
    return {1'b1, 4'hF};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    exp_digits = 32'hCCCC_CCCC;
    exp_mask   = 8'h00;
  endfunction

  // Drive one dwell (pat is active-high), then one blank cycle; update the model.
  task automatic dwell(input logic [7:0] a, input logic [6:0] pat, input int cycles);
    int   idx;
    bit   all_seen;
    logic [4:0] d;
    @(negedge clk);
    an  = a;
    seg = ~pat;
    repeat (cycles) @(negedge clk);
    an  = 8'hFF;
    seg = 7'h7F;
    if (cycles >= SETTLE) begin
      if ($countones(~a) == 1) begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
        d = ref_decode(pat);
        m_code[idx] = d[3:0];
        m_bad[idx]  = d[4];
        m_seen[idx] = 1'b1;
        all_seen = 1'b1;
        for (int i = 0; i < 8; i++) all_seen &= m_seen[i];
        if (all_seen) begin
          exp_frames++;
          for (int i = 0; i < 8; i++) begin
            exp_digits[4*i +: 4] = m_code[i];
            exp_mask[i]          = m_bad[i];
            m_seen[i]            = 1'b0;
          end
        end
      end else if ($countones(~a) > 1) begin
        exp_errs++;
      end
    end
  endtask

  task automatic dig(input int i, input logic [6:0] pat, input int cycles);
    dwell(~(8'h01 << i), pat, cycles);
  endtask

  task automatic idle_wait();
    @(negedge clk);
    an  = 8'hFF;
    seg = 7'h7F;
    repeat (WAIT_N) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    an    = 8'hFF;
    seg   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (digits !== 32'hCCCC_CCCC) begin miscompares++; $display("[TB] FAIL reset_digits: got %h want %h", digits, 32'hCCCC_CCCC); end
    vectors++; if (invalid_mask !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mask: got %h want 00", invalid_mask); end
    vectors++; if (frame_valid !== 1'b0 || an_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pulses: got fv=%b err=%b want 0 0", frame_valid, an_err); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_clock_display();
    dig(0, PAT_TAB[4], 8);
    dig(1, PAT_TAB[3], 8);
    dig(2, PAT_TAB[2], 8);
    dig(3, PAT_TAB[1], 8);
    for (int i = 4; i < 8; i++) dig(i, 7'b0000000, 8);
    idle_wait();
    vectors++; if (fv_count !== 1) begin miscompares++; $display("[TB] FAIL clock_fv_count: got %0d want 1", fv_count); end
    vectors++; if (digits !== 32'hCCCC_1234) begin miscompares++; $display("[TB] FAIL clock_digits: got %h want CCCC1234", digits); end
    vectors++; if (invalid_mask !== 8'h00) begin miscompares++; $display("[TB] FAIL clock_mask: got %h want 00", invalid_mask); end
  endtask

  task automatic test_done_glyphs();
    dig(7, PAT_TAB[13], 8);
    dig(6, PAT_TAB[11], 8);
    dig(5, PAT_TAB[10], 8);
    dig(4, PAT_TAB[14], 8);
    for (int i = 3; i >= 0; i--) dig(i, PAT_TAB[0], 8);
    idle_wait();
    vectors++; if (fv_count !== 2) begin miscompares++; $display("[TB] FAIL done_fv_count: got %0d want 2", fv_count); end
    vectors++; if (digits !== 32'hDBAE_0000) begin miscompares++; $display("[TB] FAIL done_digits: got %h want DBAE0000", digits); end
    vectors++; if (invalid_mask !== 8'h00) begin miscompares++; $display("[TB] FAIL done_mask: got %h want 00", invalid_mask); end
  endtask

  task automatic test_bad_pattern();
    for (int i = 0; i < 8; i++)
      dig(i, (i == 2) ? 7'b1000000 : PAT_TAB[$urandom_range(14)], SETTLE + 2);
    idle_wait();
    vectors++; if (digits[11:8] !== 4'hF) begin miscompares++; $display("[TB] FAIL bad_digit2: got %h want F", digits[11:8]); end
    vectors++; if (invalid_mask !== 8'h04) begin miscompares++; $display("[TB] FAIL bad_mask: got %h want 04", invalid_mask); end
    vectors++; if (digits !== exp_digits) begin miscompares++; $display("[TB] FAIL bad_digits: got %h want %h", digits, exp_digits); end
  endtask

  task automatic test_an_err();
    int fv_before;
    for (int i = 0; i < 6; i++) dig(i, PAT_TAB[$urandom_range(9)], 8);
    fv_before = fv_count;
    dwell(8'b1111_1100, PAT_TAB[8], 10);
    idle_wait();
    vectors++; if (err_count !== 1 || exp_errs !== 1) begin miscompares++; $display("[TB] FAIL an_err_pulses: got %0d want 1", err_count); end
    vectors++; if (fv_count !== fv_before) begin miscompares++; $display("[TB] FAIL an_err_no_frame: got %0d want %0d", fv_count, fv_before); end
    dig(6, PAT_TAB[6], 8);
    dig(7, PAT_TAB[7], 8);
    idle_wait();
    vectors++; if (fv_count !== exp_frames) begin miscompares++; $display("[TB] FAIL an_err_frame_count: got %0d want %0d", fv_count, exp_frames); end
    vectors++; if (digits !== exp_digits) begin miscompares++; $display("[TB] FAIL an_err_digits: got %h want %h", digits, exp_digits); end
  endtask

  task automatic test_glitch();
    int fv_before;
    fv_before = fv_count;
    dig(5, PAT_TAB[8], SETTLE - 1);
    for (int i = 0; i < 8; i++) if (i != 5) dig(i, PAT_TAB[$urandom_range(14)], 8);
    idle_wait();
    vectors++; if (fv_count !== fv_before) begin miscompares++; $display("[TB] FAIL glitch_early_frame: got %0d want %0d", fv_count, fv_before); end
    dig(5, PAT_TAB[3], 8);
    idle_wait();
    vectors++; if (fv_count !== fv_before + 1) begin miscompares++; $display("[TB] FAIL glitch_frame_count: got %0d want %0d", fv_count, fv_before + 1); end
    vectors++; if (digits[23:20] !== 4'h3) begin miscompares++; $display("[TB] FAIL glitch_digit5: got %h want 3", digits[23:20]); end
    vectors++; if (digits !== exp_digits) begin miscompares++; $display("[TB] FAIL glitch_digits: got %h want %h", digits, exp_digits); end
  endtask

  task automatic test_reset_mid_frame();
    int fv_before;
    for (int i = 0; i < 5; i++) dig(i, PAT_TAB[$urandom_range(9)], 8);
    fv_before = fv_count;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (digits !== 32'hCCCC_CCCC || frame_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_during: got %h fv=%b want CCCCCCCC 0", digits, frame_valid); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    dig(5, PAT_TAB[5], 8);
    dig(6, PAT_TAB[6], 8);
    dig(7, PAT_TAB[7], 8);
    for (int i = 0; i < 4; i++) dig(i, PAT_TAB[i], 8);
    idle_wait();
    vectors++; if (fv_count !== fv_before) begin miscompares++; $display("[TB] FAIL rst_mid_partial_kept: got %0d want %0d", fv_count, fv_before); end
    vectors++; if (digits !== 32'hCCCC_CCCC) begin miscompares++; $display("[TB] FAIL rst_mid_after: got %h want CCCCCCCC", digits); end
    dig(4, PAT_TAB[4], 8);
    idle_wait();
    vectors++; if (fv_count !== fv_before + 1) begin miscompares++; $display("[TB] FAIL rst_mid_frame_count: got %0d want %0d", fv_count, fv_before + 1); end
    vectors++; if (digits !== 32'h7654_3210) begin miscompares++; $display("[TB] FAIL rst_mid_digits: got %h want 76543210", digits); end
  endtask

  task automatic test_random_frames();
    int         perm [8];
    int         j, t;
    logic [6:0] pat;
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(3) == 0)
          dig($urandom_range(7), 7'($urandom), $urandom_range(SETTLE - 1, 1));
        pat = ($urandom_range(4) == 0) ? 7'($urandom) : PAT_TAB[$urandom_range(14)];
        dig(perm[p], pat, $urandom_range(SETTLE + 5, SETTLE));
        if (p == 4 && $urandom_range(1) == 1)
          dig(perm[0], PAT_TAB[$urandom_range(14)], SETTLE);
      end
      idle_wait();
      vectors++; if (fv_count !== exp_frames) begin miscompares++; $display("[TB] FAIL rand_frame_count[%0d]: got %0d want %0d", f, fv_count, exp_frames); end
      vectors++; if (digits !== exp_digits) begin miscompares++; $display("[TB] FAIL rand_digits[%0d]: got %h want %h", f, digits, exp_digits); end
      vectors++; if (invalid_mask !== exp_mask) begin miscompares++; $display("[TB] FAIL rand_mask[%0d]: got %h want %h", f, invalid_mask, exp_mask); end
      vectors++; if (err_count !== exp_errs) begin miscompares++; $display("[TB] FAIL rand_an_err[%0d]: got %0d want %0d", f, err_count, exp_errs); end
    end
  endtask

  initial begin
    test_reset();
    test_clock_display();
    test_done_glyphs();
    test_bad_pattern();
    test_an_err();
    test_glitch();
    test_reset_mid_frame();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the 8-digit multiplexed seven-segment display driver.
- Watches the scanned anode/segment bus and decodes each segment pattern back to a 4-bit glyph code.
- Assembles the 8 decoded digits into a frame and presents the whole frame at once.
- Used for on-chip readback of the timer display (minutes/seconds digits and the "donE" glyphs) and as a bench monitor.

Parameters:
- SETTLE_CYCLES, 4, number of consecutive cycles an and seg must be unchanged before a digit is sampled; legal range 1..255.
- SYNC_STAGES, 2, depth of input synchronizer on an and seg; legal range 2..3.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous active-high reset.
- an  input  8  anode selects, active low; an[i]=0 selects digit i.
- seg  input  7  segments {g,f,e,d,c,b,a}, active low.
- digits  output  32  last complete frame; digits[4i+3:4i] is the glyph code of digit i.
- invalid_mask  output  8  bit i set if digit i of the last frame held an unrecognised pattern.
- frame_valid  output  1  one-cycle pulse when digits/invalid_mask update.
- an_err  output  1  one-cycle pulse when a settled an has more than one bit low.

Behaviour:
- Reset values: digits=32'hCCCC_CCCC (all blank), invalid_mask=0, frame_valid=0, an_err=0. Internal state is cleared too: shadow regs, seen mask, settle counter, captured flag and sync stages (set to all-ones, i.e. idle bus).
- Reset asserted mid-frame discards the partial frame. It has priority over every other event in the same cycle.
- Sync: an and seg pass through SYNC_STAGES flops. All decisions use the synced values (an_s, seg_s).
- Settle counter:
  - Cleared whenever {an_s, seg_s} differs from its previous-cycle value; the captured flag is cleared at the same time.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A "settled" event fires on the single cycle the counter reaches SETTLE_CYCLES-1 with captured=0; captured is then set. This gives exactly one event per dwell. With SETTLE_CYCLES=1 the event fires on the first cycle of a new value.
- On a settled event, by an_s:
  - all ones: blanking interval; no action.
  - exactly one zero at bit i: decode seg_s, write the code into shadow[i], set seen[i], record the invalid bit for i.
  - two or more zeros: assert an_err on the next cycle; no capture.
- Decode uses active-low inversion; the active-high pattern is shown as {g..a}:
  - Digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, codes 0x0-0x9.
  - Glyphs: n=1010100 -> 0xA; o=1011100 -> 0xB; blank=0000000 -> 0xC; d=1011110 -> 0xD; E=1111001 -> 0xE.
  - Any other pattern -> 0xF with the invalid bit set.
- Frame completion:
  - When a capture makes seen==8'hFF, on the next cycle digits<=shadow (including the digit just written), invalid_mask<=the recorded invalid bits, frame_valid=1, and seen clears.
  - Outputs update atomically; they never show a partial frame.
- Recapture: a repeated digit before the frame completes overwrites shadow[i]; the last value wins.
- Latency: input change to capture = SYNC_STAGES + SETTLE_CYCLES cycles. Capture to frame_valid = 1 cycle.
- Scan order is irrelevant; any order covering all 8 digits completes a frame.
- A dwell shorter than SETTLE_CYCLES is ignored: no capture, no error.

Decomposition:
- Shared package seg_scan_pkg holds:
  - glyph code constants (GLYPH_N, GLYPH_O, GLYPH_BLANK, GLYPH_D, GLYPH_E, GLYPH_BAD);
  - the 15 active-high segment pattern constants;
  - NUM_DIGITS=8.
- One combinational sub-module, seg7_decode: 7-bit active-low pattern in, 4-bit code plus invalid flag out. It is the inverse of the team's segment encoder.
- Top module holds the synchronizer, settle counter, shadow/seen registers and frame output.

Test Plan:
- Scan "12:34" digits, i.e. digits 0..3 = 4,3,2,1 and digits 4..7 blank, each dwell 8 cycles (SETTLE_CYCLES=4) -> one frame_valid pulse; digits=32'hCCCC_1234; invalid_mask=0.
- Scan "donE" on digits 7..4 (d,o,n,E) plus "0000" on digits 3..0 -> digits=32'hDBAE_0000; invalid_mask=0.
- Digit 2 driven with pattern 1000000 active-high (segment g only) -> digits[11:8]=4'hF; invalid_mask=8'h04.
- an=8'b1111_1100 held 10 cycles -> exactly one an_err pulse; seen unchanged; no frame_valid until a full valid scan follows.
- Glitch: digit 5 dwell of 3 cycles, then a full scan at 8-cycle dwells -> first glitch produces no capture; frame_valid only after all 8 legitimate dwells; digit 5 holds the legitimate value.
- Reset asserted after 5 digits captured, then 8 digits scanned -> digits=32'hCCCC_CCCC and frame_valid=0 during and after reset, until the 8th post-reset capture + 1 cycle.
